fft_wm_arbiter: RTL and testbench

//  Shares one complex twiddle multiplier (fft_wm-style datapath, fixed latency, no stall)

---
 rtl/fft_wm_arbiter_if.sv | 40 ++++
 rtl/fft_wm_arbiter.sv | 99 +++++++++
 tb/tb_fft_wm_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_wm_arbiter_if.sv
// Requester and multiplier bus of the shared twiddle-multiplier arbiter.
// Signals keep their arbiter-side direction suffixes so both ends read the same way.
interface fft_wm_arbiter_if #(
  parameter int DATA_WIDTH    = 25,
  parameter int TWIDDLE_WIDTH = 10,
  parameter int NREQ          = 4,
  parameter int INFL_WIDTH    = 3
);
  logic [NREQ-1:0]               req_valid_i;
  logic [NREQ-1:0]               req_ready_o;
  logic [NREQ*DATA_WIDTH-1:0]    req_x_re_i;
  logic [NREQ*DATA_WIDTH-1:0]    req_x_im_i;
  logic [NREQ*TWIDDLE_WIDTH-1:0] req_w_re_i;
  logic [NREQ*TWIDDLE_WIDTH-1:0] req_w_im_i;
  logic [DATA_WIDTH-1:0]         mul_x_re_o;
  logic [DATA_WIDTH-1:0]         mul_x_im_o;
  logic [TWIDDLE_WIDTH-1:0]      mul_w_re_o;
  logic [TWIDDLE_WIDTH-1:0]      mul_w_im_o;
  logic [DATA_WIDTH-1:0]         mul_z_re_i;
  logic [DATA_WIDTH-1:0]         mul_z_im_i;
  logic [NREQ-1:0]               resp_valid_o;
  logic [DATA_WIDTH-1:0]         resp_z_re_o;
  logic [DATA_WIDTH-1:0]         resp_z_im_o;
  logic [INFL_WIDTH-1:0]         inflight_o;

  // Requesters plus the multiplier; they drive operands and products.
  modport master (
    output req_valid_i, req_x_re_i, req_x_im_i, req_w_re_i, req_w_im_i,
    output mul_z_re_i, mul_z_im_i,
    input  req_ready_o, mul_x_re_o, mul_x_im_o, mul_w_re_o, mul_w_im_o,
    input  resp_valid_o, resp_z_re_o, resp_z_im_o, inflight_o
  );

  modport slave (
    input  req_valid_i, req_x_re_i, req_x_im_i, req_w_re_i, req_w_im_i,
    input  mul_z_re_i, mul_z_im_i,
    output req_ready_o, mul_x_re_o, mul_x_im_o, mul_w_re_o, mul_w_im_o,
    output resp_valid_o, resp_z_re_o, resp_z_im_o, inflight_o
  );
endinterface

// File: rtl/fft_wm_arbiter.sv
// Round-robin sharing of one fixed-latency complex twiddle multiplier between NREQ
// requesters; a tag pipe matching the multiplier latency routes each product home.
module fft_wm_arbiter #(
  parameter int DATA_WIDTH    = 25,
  parameter int TWIDDLE_WIDTH = 10,
  parameter int NREQ          = 4,
  parameter int REQ_LOG2      = 2,
  parameter int MUL_LATENCY   = 4,
  parameter int INFL_WIDTH    = 3
) (
  input logic              clk_i,
  input logic              rst_n,
  fft_wm_arbiter_if.slave  bus
);

  localparam int DEPTH = MUL_LATENCY + 1;

  logic [REQ_LOG2-1:0]      ptr;
  logic [REQ_LOG2-1:0]      grant_idx;
  logic                     found;
  logic [NREQ-1:0]          ready;
  logic                     accept;
  logic [DEPTH-1:0]         tag_v;
  logic [REQ_LOG2-1:0]      tag_t [DEPTH];
  logic                     ret;
  logic [DATA_WIDTH-1:0]    x_re_q, x_im_q, z_re_q, z_im_q;
  logic [TWIDDLE_WIDTH-1:0] w_re_q, w_im_q;
  logic [NREQ-1:0]          resp_valid_q;
  logic [INFL_WIDTH-1:0]    inflight_q;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    ready     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid_i[(int'(ptr) + i) % NREQ]) begin
        found     = 1'b1;
        grant_idx = REQ_LOG2'((int'(ptr) + i) % NREQ);
      end
    end
    if (found && rst_n) ready[grant_idx] = 1'b1;
  end

  assign accept = |(bus.req_valid_i & ready);
  assign ret    = tag_v[DEPTH-1];

  // Tags carry no reset; only their valid bits decide whether a product is returned.
  always_ff @(posedge clk_i) begin
    tag_t[0] <= grant_idx;
    for (int i = 1; i < DEPTH; i++) tag_t[i] <= tag_t[i-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ptr          <= '0;
      tag_v        <= '0;
      x_re_q       <= '0;
      x_im_q       <= '0;
      w_re_q       <= '0;
      w_im_q       <= '0;
      resp_valid_q <= '0;
      z_re_q       <= '0;
      z_im_q       <= '0;
      inflight_q   <= '0;
    end else begin
      tag_v <= {tag_v[DEPTH-2:0], accept};
      if (accept) begin
        ptr    <= REQ_LOG2'((int'(grant_idx) + 1) % NREQ);
        x_re_q <= bus.req_x_re_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        x_im_q <= bus.req_x_im_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        w_re_q <= bus.req_w_re_i[int'(grant_idx)*TWIDDLE_WIDTH +: TWIDDLE_WIDTH];
        w_im_q <= bus.req_w_im_i[int'(grant_idx)*TWIDDLE_WIDTH +: TWIDDLE_WIDTH];
      end
      resp_valid_q <= '0;
      if (ret) begin
        resp_valid_q[tag_t[DEPTH-1]] <= 1'b1;
        z_re_q                       <= bus.mul_z_re_i;
        z_im_q                       <= bus.mul_z_im_i;
      end
      case ({accept, ret})
        2'b10:   inflight_q <= inflight_q + INFL_WIDTH'(1);
        2'b01:   inflight_q <= inflight_q - INFL_WIDTH'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.mul_x_re_o   = x_re_q;
  assign bus.mul_x_im_o   = x_im_q;
  assign bus.mul_w_re_o   = w_re_q;
  assign bus.mul_w_im_o   = w_im_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_z_re_o  = z_re_q;
  assign bus.resp_z_im_o  = z_im_q;
  assign bus.inflight_o   = inflight_q;

endmodule

// File: tb/tb_fft_wm_arbiter.sv
// Directed bench for fft_wm_arbiter; the multiplier is modelled as a delay line
// computing z_re = x_re + w_re, z_im = x_im - w_im.
module tb_fft_wm_arbiter;
  localparam int DW = 25;
  localparam int TW = 10;
  localparam int NR = 4;
  localparam int ML = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fft_wm_arbiter_if #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .NREQ(NR), .INFL_WIDTH(IW)) bus ();

  fft_wm_arbiter #(
    .DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .NREQ(NR), .REQ_LOG2(2),
    .MUL_LATENCY(ML), .INFL_WIDTH(IW)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] d_re [ML];
  logic [DW-1:0] d_im [ML];

  always @(posedge clk) begin
    d_re[0] <= $signed(bus.mul_x_re_o) + $signed(bus.mul_w_re_o);
    d_im[0] <= $signed(bus.mul_x_im_o) - $signed(bus.mul_w_im_o);
    for (int i = 1; i < ML; i++) begin
      d_re[i] <= d_re[i-1];
      d_im[i] <= d_im[i-1];
    end
  end

  assign bus.mul_z_re_i = d_re[ML-1];
  assign bus.mul_z_im_i = d_im[ML-1];

  task automatic set_req(input int k, input int xr, input int xi, input int wr, input int wi);
    bus.req_x_re_i[k*DW +: DW] = DW'(xr);
    bus.req_x_im_i[k*DW +: DW] = DW'(xi);
    bus.req_w_re_i[k*TW +: TW] = TW'(wr);
    bus.req_w_im_i[k*TW +: TW] = TW'(wi);
  endtask

  task automatic clear_reqs();
    bus.req_valid_i = '0;
    bus.req_x_re_i  = '0;
    bus.req_x_im_i  = '0;
    bus.req_w_re_i  = '0;
    bus.req_w_im_i  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    bus.req_valid_i = 4'b1111;
    #1;
    total++; if (bus.req_ready_o !== 4'b0000) begin bad++; $display("[TB] FAIL rst_ready got=%b exp=0000", bus.req_ready_o); end
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.mul_x_re_o !== '0) begin bad++; $display("[TB] FAIL rst_mul_x_re got=%0h exp=0", bus.mul_x_re_o); end
    total++; if (bus.mul_w_im_o !== '0) begin bad++; $display("[TB] FAIL rst_mul_w_im got=%0h exp=0", bus.mul_w_im_o); end
    total++; if (bus.resp_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL rst_resp_valid got=%b exp=0000", bus.resp_valid_o); end
    total++; if (bus.resp_z_re_o !== '0) begin bad++; $display("[TB] FAIL rst_resp_z_re got=%0h exp=0", bus.resp_z_re_o); end
    total++; if (bus.inflight_o !== 3'd0) begin bad++; $display("[TB] FAIL rst_inflight got=%0d exp=0", bus.inflight_o); end
    rst_n = 1'b1;
    bus.req_valid_i = '0;
  endtask

  task automatic test_single();
    bus.req_valid_i = 4'b0001;
    set_req(0, 100, -7, 3, 2);
    #1;
    total++; if (bus.req_ready_o !== 4'b0001) begin bad++; $display("[TB] FAIL t1_ready got=%b exp=0001", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = '0;
    total++; if (bus.mul_x_re_o !== DW'(100)) begin bad++; $display("[TB] FAIL t1_mul_x_re got=%0d exp=100", $signed(bus.mul_x_re_o)); end
    total++; if (bus.mul_x_im_o !== DW'(-7)) begin bad++; $display("[TB] FAIL t1_mul_x_im got=%0d exp=-7", $signed(bus.mul_x_im_o)); end
    total++; if (bus.inflight_o !== 3'd1) begin bad++; $display("[TB] FAIL t1_inflight_1 got=%0d exp=1", bus.inflight_o); end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      total++; if (bus.resp_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL t1_early_resp n=%0d got=%b exp=0000", n, bus.resp_valid_o); end
    end
    @(negedge clk);
    total++; if (bus.resp_valid_o !== 4'b0001) begin bad++; $display("[TB] FAIL t1_resp_valid got=%b exp=0001", bus.resp_valid_o); end
    total++; if (bus.resp_z_re_o !== DW'(103)) begin bad++; $display("[TB] FAIL t1_z_re got=%0d exp=103", $signed(bus.resp_z_re_o)); end
    total++; if (bus.resp_z_im_o !== DW'(-9)) begin bad++; $display("[TB] FAIL t1_z_im got=%0d exp=-9", $signed(bus.resp_z_im_o)); end
    total++; if (bus.inflight_o !== 3'd0) begin bad++; $display("[TB] FAIL t1_inflight_0 got=%0d exp=0", bus.inflight_o); end
    @(negedge clk);
    total++; if (bus.resp_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL t1_strobe_len got=%b exp=0000", bus.resp_valid_o); end
    total++; if (bus.resp_z_re_o !== DW'(103)) begin bad++; $display("[TB] FAIL t1_z_hold got=%0d exp=103", $signed(bus.resp_z_re_o)); end
  endtask

  task automatic test_all_valid();
    int            peak;
    int            j;
    int            exp_inf;
    int            acc;
    int            rsp;
    logic [NR-1:0] exp_rv;
    logic [NR-1:0] exp_rdy;
    do_reset();
    peak = 0;
    for (int c = 0; c <= 14; c++) begin
      // Outputs here reflect the edges following drive cycles 0..c-1.
      j = c - 6;
      exp_rv = '0;
      if (j >= 0 && j < 8) exp_rv[j % 4] = 1'b1;
      acc = (c < 8) ? c : 8;
      rsp = (c - 5 < 0) ? 0 : ((c - 5 > 8) ? 8 : c - 5);
      exp_inf = acc - rsp;
      total++; if (bus.resp_valid_o !== exp_rv) begin bad++; $display("[TB] FAIL t2_resp_valid c=%0d got=%b exp=%b", c, bus.resp_valid_o, exp_rv); end
      if (j >= 0 && j < 8) begin
        total++; if (bus.resp_z_re_o !== DW'(17*j + j%4)) begin bad++; $display("[TB] FAIL t2_z_re c=%0d got=%0d exp=%0d", c, $signed(bus.resp_z_re_o), 17*j + j%4); end
        total++; if (bus.resp_z_im_o !== DW'(-j - 2)) begin bad++; $display("[TB] FAIL t2_z_im c=%0d got=%0d exp=%0d", c, $signed(bus.resp_z_im_o), -j - 2); end
      end
      total++; if (bus.inflight_o !== IW'(exp_inf)) begin bad++; $display("[TB] FAIL t2_inflight c=%0d got=%0d exp=%0d", c, bus.inflight_o, exp_inf); end
      if (int'(bus.inflight_o) > peak) peak = int'(bus.inflight_o);
      if (c < 8) begin
        bus.req_valid_i = 4'b1111;
        for (int k = 0; k < NR; k++) set_req(k, 16*c + k, -c, c, 2);
        exp_rdy = '0;
        exp_rdy[c % 4] = 1'b1;
        #1;
        total++; if (bus.req_ready_o !== exp_rdy) begin bad++; $display("[TB] FAIL t2_grant c=%0d got=%b exp=%b", c, bus.req_ready_o, exp_rdy); end
      end else begin
        bus.req_valid_i = '0;
      end
      @(negedge clk);
    end
    total++; if (peak != 5) begin bad++; $display("[TB] FAIL t2_peak got=%0d exp=5", peak); end
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int k = 0; k < NR; k++) set_req(k, 500 + k, k, 1, 1);
    bus.req_valid_i = 4'b1000;
    #1;
    total++; if (bus.req_ready_o !== 4'b1000) begin bad++; $display("[TB] FAIL t3_grant3 got=%b exp=1000", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = 4'b1100;
    #1;
    total++; if (bus.req_ready_o !== 4'b0100) begin bad++; $display("[TB] FAIL t3_grant2 got=%b exp=0100", bus.req_ready_o); end
    @(negedge clk);
    #1;
    total++; if (bus.req_ready_o !== 4'b1000) begin bad++; $display("[TB] FAIL t3_grant3b got=%b exp=1000", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = 4'b0010;
    #1;
    total++; if (bus.req_ready_o !== 4'b0010) begin bad++; $display("[TB] FAIL t3_grant1 got=%b exp=0010", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = '0;
    total++; if (bus.mul_x_re_o !== DW'(501)) begin bad++; $display("[TB] FAIL t3_operand got=%0d exp=501", $signed(bus.mul_x_re_o)); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_req(0, 7, 7, 1, 1);
    bus.req_valid_i = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.req_ready_o !== 4'b0001) begin bad++; $display("[TB] FAIL t4_grant c=%0d got=%b exp=0001", c, bus.req_ready_o); end
      @(negedge clk);
    end
    total++; if (bus.inflight_o !== 3'd3) begin bad++; $display("[TB] FAIL t4_inflight3 got=%0d exp=3", bus.inflight_o); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.req_ready_o !== 4'b0000) begin bad++; $display("[TB] FAIL t4_ready_in_reset got=%b exp=0000", bus.req_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid_i = '0;
    total++; if (bus.mul_x_re_o !== '0) begin bad++; $display("[TB] FAIL t4_mul_cleared got=%0d exp=0", $signed(bus.mul_x_re_o)); end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      total++; if (bus.resp_valid_o !== 4'b0000) begin bad++; $display("[TB] FAIL t4_ghost_resp n=%0d got=%b exp=0000", n, bus.resp_valid_o); end
      total++; if (bus.inflight_o !== 3'd0) begin bad++; $display("[TB] FAIL t4_inflight n=%0d got=%0d exp=0", n, bus.inflight_o); end
    end
    bus.req_valid_i = 4'b1111;
    #1;
    total++; if (bus.req_ready_o !== 4'b0001) begin bad++; $display("[TB] FAIL t4_ptr_zero got=%b exp=0001", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = '0;
  endtask

  task automatic test_no_starve();
    int            g1;
    logic [NR-1:0] exp_rdy;
    do_reset();
    set_req(1, 11, 0, 0, 0);
    set_req(2, 22, 0, 0, 0);
    g1 = 0;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid_i = (c % 2 == 0) ? 4'b0110 : 4'b0100;
      exp_rdy = (c % 2 == 0) ? 4'b0010 : 4'b0100;
      #1;
      total++; if (bus.req_ready_o !== exp_rdy) begin bad++; $display("[TB] FAIL t5_grant c=%0d got=%b exp=%b", c, bus.req_ready_o, exp_rdy); end
      if (bus.req_ready_o[1] === 1'b1) g1++;
      @(negedge clk);
    end
    bus.req_valid_i = '0;
    total++; if (g1 != 4) begin bad++; $display("[TB] FAIL t5_req1_grants got=%0d exp=4", g1); end
  endtask

  task automatic test_same_edge();
    do_reset();
    set_req(0, 40, 1, 2, 1);
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    bus.req_valid_i = '0;
    total++; if (bus.inflight_o !== 3'd1) begin bad++; $display("[TB] FAIL t6_inflight_a got=%0d exp=1", bus.inflight_o); end
    repeat (4) @(negedge clk);
    set_req(0, 60, 5, 1, 1);
    bus.req_valid_i = 4'b0001;
    #1;
    total++; if (bus.req_ready_o !== 4'b0001) begin bad++; $display("[TB] FAIL t6_grant got=%b exp=0001", bus.req_ready_o); end
    @(negedge clk);
    bus.req_valid_i = '0;
    total++; if (bus.resp_valid_o !== 4'b0001) begin bad++; $display("[TB] FAIL t6_resp_first got=%b exp=0001", bus.resp_valid_o); end
    total++; if (bus.resp_z_re_o !== DW'(42)) begin bad++; $display("[TB] FAIL t6_z_first got=%0d exp=42", $signed(bus.resp_z_re_o)); end
    total++; if (bus.inflight_o !== 3'd1) begin bad++; $display("[TB] FAIL t6_inflight_same got=%0d exp=1", bus.inflight_o); end
    repeat (5) @(negedge clk);
    total++; if (bus.resp_valid_o !== 4'b0001) begin bad++; $display("[TB] FAIL t6_resp_second got=%b exp=0001", bus.resp_valid_o); end
    total++; if (bus.resp_z_re_o !== DW'(61)) begin bad++; $display("[TB] FAIL t6_z_re_second got=%0d exp=61", $signed(bus.resp_z_re_o)); end
    total++; if (bus.resp_z_im_o !== DW'(4)) begin bad++; $display("[TB] FAIL t6_z_im_second got=%0d exp=4", $signed(bus.resp_z_im_o)); end
    total++; if (bus.inflight_o !== 3'd0) begin bad++; $display("[TB] FAIL t6_inflight_end got=%0d exp=0", bus.inflight_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_all_valid();
    test_rr_order();
    test_reset_midflight();
    test_no_starve();
    test_same_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
